// File: rtl/rtc_scan.sv
// rtc_scan: walks nine RTC date/time/timer registers, reads each one over a
// simple request/acknowledge bus and presents the decoded BCD digit pair to a
// downstream display stage for a fixed number of cycles.
//
// Handshake: rd_req rises with rd_addr and both stay constant until rd_ack is
// seen high on a rising edge of reloj. rd_data is sampled on that same edge.
// rd_req is low on the following cycle. An rd_ack that arrives while rd_req is
// low is ignored. A request with no rd_ack for TIMEOUT_CYC cycles is abandoned.
module rtc_scan #(
  parameter int HOLD_CYC    = 4,
  parameter int REFRESH_CYC = 100000,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic       reloj,
  input  logic       reset,
  input  logic       en,
  output logic       rd_req,
  output logic [7:0] rd_addr,
  input  logic       rd_ack,
  input  logic [7:0] rd_data,
  output logic [3:0] decenas,
  output logic [3:0] unidades,
  output logic [3:0] direccion,
  output logic       valid,
  output logic       busy,
  output logic       bcd_err,
  output logic       to_err,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    PRESENT = 2'd2,
    GAP     = 2'd3
  } state_t;

  localparam int RW = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  localparam logic [RW-1:0] REF_LAST  = RW'(REFRESH_CYC - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
  localparam logic [3:0]    LAST_IDX  = 4'd8;
  localparam logic [3:0]    NO_FIELD  = 4'hF;

  state_t        state;
  state_t        state_nxt;
  logic [3:0]    idx;
  logic [RW-1:0] ref_cnt;
  logic [TW-1:0] to_cnt;
  logic [HW-1:0] hold_cnt;

  logic [3:0]    cap_t;
  logic [3:0]    cap_u;
  logic          cap_err;
  logic          ack_take;
  logic          timed_out;
  logic          scan_end;

  // RTC register address for each field index.
  function automatic logic [7:0] field_addr(input logic [3:0] i);
    case (i)
      4'd0:    return 8'h24;  // day
      4'd1:    return 8'h25;  // month
      4'd2:    return 8'h26;  // year
      4'd3:    return 8'h23;  // hour
      4'd4:    return 8'h22;  // minute
      4'd5:    return 8'h21;  // second
      4'd6:    return 8'h43;  // timer hour
      4'd7:    return 8'h42;  // timer minute
      4'd8:    return 8'h41;  // timer second
      default: return 8'h00;
    endcase
  endfunction

  // Per-cycle event qualifiers shared by the FSM and the datapath.
  always_comb begin
    ack_take  = (state == REQ) && rd_ack;
    timed_out = (state == REQ) && !rd_ack && (to_cnt == TO_LAST);
    scan_end  = (idx == LAST_IDX) || !en;
  end

  // Decode the packed BCD byte; hour registers carry format bits in [7:6].
  always_comb begin
    cap_err = 1'b0;
    if ((idx == 4'd3) || (idx == 4'd6)) begin
      cap_t = {2'b00, rd_data[5:4]};
    end else begin
      cap_t = rd_data[7:4];
    end
    cap_u = rd_data[3:0];
    if (cap_t > 4'd9) begin
      cap_t   = 4'd0;
      cap_err = 1'b1;
    end
    if (cap_u > 4'd9) begin
      cap_u   = 4'd0;
      cap_err = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge reloj or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (en && (ref_cnt == REF_LAST)) state_nxt = REQ;
      end
      REQ: begin
        if (rd_ack) begin
          state_nxt = PRESENT;
        end else if (to_cnt == TO_LAST) begin
          state_nxt = GAP;
        end
      end
      PRESENT: begin
        if (hold_cnt == HOLD_LAST) state_nxt = GAP;
      end
      GAP: begin
        state_nxt = scan_end ? IDLE : REQ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    rd_req    = (state == REQ);
    rd_addr   = rd_req ? field_addr(idx) : 8'h00;
    valid     = (state == PRESENT);
    direccion = valid ? idx : NO_FIELD;
    busy      = (state != IDLE);
    state_dbg = state;
  end

  // Refresh counter: runs in IDLE and waits at its last value while disabled.
  always_ff @(posedge reloj or negedge reset) begin
    if (!reset) begin
      ref_cnt <= '0;
    end else if (state == IDLE) begin
      if (ref_cnt != REF_LAST) ref_cnt <= ref_cnt + 1'b1;
    end else begin
      ref_cnt <= '0;
    end
  end

  // Request timeout counter, cleared whenever no request is outstanding.
  always_ff @(posedge reloj or negedge reset) begin
    if (!reset) begin
      to_cnt <= '0;
    end else if (state == REQ) begin
      to_cnt <= to_cnt + 1'b1;
    end else begin
      to_cnt <= '0;
    end
  end

  // Presentation length counter.
  always_ff @(posedge reloj or negedge reset) begin
    if (!reset) begin
      hold_cnt <= '0;
    end else if (state == PRESENT) begin
      hold_cnt <= hold_cnt + 1'b1;
    end else begin
      hold_cnt <= '0;
    end
  end

  // Field index: advances on every GAP, whether or not the field was shown.
  always_ff @(posedge reloj or negedge reset) begin
    if (!reset) begin
      idx <= 4'd0;
    end else if (state == GAP) begin
      idx <= scan_end ? 4'd0 : idx + 4'd1;
    end else if (state == IDLE) begin
      idx <= 4'd0;
    end
  end

  // Digit capture; the digits keep their value until the next accepted read.
  always_ff @(posedge reloj or negedge reset) begin
    if (!reset) begin
      decenas  <= 4'd0;
      unidades <= 4'd0;
    end else if (ack_take) begin
      decenas  <= cap_t;
      unidades <= cap_u;
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge reloj or negedge reset) begin
    if (!reset) begin
      bcd_err <= 1'b0;
      to_err  <= 1'b0;
    end else begin
      if (ack_take && cap_err) bcd_err <= 1'b1;
      if (timed_out)           to_err  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rtc_scan.sv
// tb_rtc_scan: directed scans of rtc_scan against an event-level model of the
// scan (request order, presentation contents and lengths, GAP/refresh timing,
// sticky flags), plus literal expectations for each scenario.
module tb_rtc_scan;

  localparam int HOLD = 4;
  localparam int RC   = 8;
  localparam int TO   = 255;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       en = 1'b0;
  logic       rd_req;
  logic [7:0] rd_addr;
  logic       rd_ack;
  logic [7:0] rd_data;
  logic [3:0] decenas;
  logic [3:0] unidades;
  logic [3:0] direccion;
  logic       valid;
  logic       busy;
  logic       bcd_err;
  logic       to_err;
  logic [1:0] state_dbg;

  rtc_scan #(
    .HOLD_CYC    (HOLD),
    .REFRESH_CYC (RC),
    .TIMEOUT_CYC (TO)
  ) dut (
    .reloj     (clk),
    .reset     (rst_n),
    .en        (en),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_ack    (rd_ack),
    .rd_data   (rd_data),
    .decenas   (decenas),
    .unidades  (unidades),
    .direccion (direccion),
    .valid     (valid),
    .busy      (busy),
    .bcd_err   (bcd_err),
    .to_err    (to_err),
    .state_dbg (state_dbg)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference tables and decode ----------------
  logic [7:0] map_tab [9] = '{8'h24, 8'h25, 8'h26, 8'h23, 8'h22, 8'h21, 8'h43, 8'h42, 8'h41};
  logic [7:0] base_resp [9] = '{8'h31, 8'h12, 8'h16, 8'h23, 8'h59, 8'h07, 8'h01, 8'h30, 8'h45};
  logic [11:0] s1_exp [9] = '{12'h031, 12'h112, 12'h216, 12'h323, 12'h459,
                              12'h507, 12'h601, 12'h730, 12'h845};

  // Returns {err, tens, units} for a field index and raw register byte.
  function automatic logic [8:0] decode(input int i, input logic [7:0] d);
    logic [3:0] t;
    logic [3:0] u;
    logic       e;
    t = ((i == 3) || (i == 6)) ? {2'b00, d[5:4]} : d[7:4];
    u = d[3:0];
    e = 1'b0;
    if (t > 4'd9) begin t = 4'd0; e = 1'b1; end
    if (u > 4'd9) begin u = 4'd0; e = 1'b1; end
    return {e, t, u};
  endfunction

  function automatic int addr_idx(input logic [7:0] a);
    for (int i = 0; i < 9; i++) if (map_tab[i] == a) return i;
    return 15;
  endfunction

  // ---------------- bus responder (driver) ----------------
  logic [7:0] resp [9];
  int         mute_idx = -1;
  logic       spur     = 1'b0;

  initial begin
    int wcnt;
    int ri;
    wcnt    = 0;
    rd_ack  = 1'b0;
    rd_data = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      rd_ack = 1'b0;
      if (rd_req) begin
        ri = addr_idx(rd_addr);
        if (ri < 9 && ri != mute_idx) begin
          wcnt++;
          if (wcnt == 3) begin
            rd_ack  = 1'b1;
            rd_data = resp[ri];
            wcnt    = 0;
          end
        end
      end else begin
        wcnt = 0;
        if (spur) begin
          rd_ack  = 1'b1;
          rd_data = 8'hFF;
        end
      end
    end
  end

  // ---------------- scoreboard / model ----------------
  logic [11:0] exp_q[$];
  logic [11:0] log_q[$];
  int   m_idx = 0, req_run = 0, val_run = 0, idle_cnt = 0, after_gap = 0;
  logic in_scan = 0, acked = 0, prev_req = 0, prev_valid = 0, en_held = 1;
  logic exp_bcd = 0, exp_to = 0;
  logic [3:0] last_t = 0, last_u = 0;

  // End of a request or presentation: this cycle is the single GAP cycle.
  task automatic gap_decide();
    chk("gap_outs", {busy, rd_req, valid}, 3'b100);
    if (m_idx == 8 || !en) begin
      after_gap = 2;
    end else begin
      after_gap = 1;
      m_idx++;
    end
  endtask

  always @(negedge clk) begin
    logic       exp_rise;
    logic [8:0] r;
    logic [11:0] e;
    if (!rst_n) begin
      chk("reset_outs",
          {rd_req, rd_addr, decenas, unidades, direccion, valid, busy, bcd_err, to_err},
          {1'b0, 8'h00, 4'h0, 4'h0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0});
      in_scan = 0; m_idx = 0; req_run = 0; acked = 0; val_run = 0;
      prev_req = 0; prev_valid = 0; idle_cnt = 0; en_held = 1; after_gap = 0;
      exp_bcd = 0; exp_to = 0; last_t = 0; last_u = 0;
      exp_q.delete();
      log_q.delete();
    end else begin
      exp_rise = (after_gap == 1);
      if (after_gap == 1) chk("gap_to_req", rd_req, 1);
      if (after_gap == 2) begin
        chk("gap_to_idle", busy, 0);
        in_scan = 0; idle_cnt = 0; en_held = 1;
      end
      after_gap = 0;
      if (rd_req && !prev_req) begin
        if (!in_scan) begin
          if (en_held) chk("refresh_gap", idle_cnt, RC);
          else         chk("refresh_min", (idle_cnt >= RC), 1);
          in_scan = 1; m_idx = 0;
        end else begin
          chk("req_rise", exp_rise, 1);
        end
      end
      if (!in_scan) begin
        idle_cnt++;
        if (!en) en_held = 0;
      end
      if (rd_req) begin
        req_run++;
        chk("rd_addr", rd_addr, map_tab[m_idx]);
      end
      if (!rd_req && prev_req) begin
        if (acked) begin
          chk("present_start", valid, 1);
        end else begin
          chk("timeout_len", req_run, TO);
          exp_to = 1;
          gap_decide();
        end
        req_run = 0;
      end
      if (!valid && prev_valid) begin
        chk("hold_len", val_run, HOLD);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          last_t = e[7:4];
          last_u = e[3:0];
        end
        val_run = 0; acked = 0;
        gap_decide();
      end
      if (valid) begin
        if (exp_q.size() == 0) chk("valid_unexp", valid, 0);
        else chk("present", {direccion, decenas, unidades}, exp_q[0]);
        val_run++;
      end else begin
        chk("idle_outs", {direccion, decenas, unidades}, {4'hF, last_t, last_u});
      end
      chk("flags", {bcd_err, to_err}, {exp_bcd, exp_to});
      chk("busy", busy, in_scan);
      if (rd_req && rd_ack) begin
        r = decode(m_idx, rd_data);
        e = {4'(m_idx), r[7:0]};
        exp_q.push_back(e);
        log_q.push_back(e);
        if (r[8]) exp_bcd = 1;
        acked = 1;
      end
      prev_req   = rd_req;
      prev_valid = valid;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_scan(input string nm);
    int n;
    n = 0;
    while (!busy && n < 200) begin @(negedge clk); n++; end
    chk({nm, "_start"}, busy, 1);
    n = 0;
    while (busy && n < 2000) begin @(negedge clk); n++; end
    chk({nm, "_end"}, busy, 0);
  endtask

  initial begin
    int n;
    int reqs;
    int hit21;
    for (int i = 0; i < 9; i++) resp[i] = base_resp[i];
    chk("pin_hour_decode", decode(3, 8'hA3), 9'h023);
    chk("pin_min_decode", decode(4, 8'h7C), 9'h170);

    // Reset, then a plain scan with spurious acks outside requests.
    en   = 1'b1;
    spur = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_scan("scan1");
    spur = 1'b0;
    chk("scan1_count", log_q.size(), 9);
    for (int i = 0; i < 9; i++) if (i < log_q.size()) chk("scan1_pair", log_q[i], s1_exp[i]);
    chk("scan1_flags", {bcd_err, to_err}, 2'b00);

    // Hour with format bits set, minute with an illegal units nibble.
    log_q.delete();
    resp[3] = 8'hA3;
    resp[4] = 8'h7C;
    wait_scan("scan2");
    chk("scan2_count", log_q.size(), 9);
    if (log_q.size() == 9) begin
      chk("scan2_hour", log_q[3], 12'h323);
      chk("scan2_min", log_q[4], 12'h470);
    end
    chk("scan2_bcd_sticky", bcd_err, 1);

    // Year register never answers.
    log_q.delete();
    for (int i = 0; i < 9; i++) resp[i] = base_resp[i];
    mute_idx = 2;
    wait_scan("scan3");
    mute_idx = -1;
    chk("scan3_to_err", to_err, 1);
    chk("scan3_count", log_q.size(), 8);
    if (log_q.size() == 8) chk("scan3_after_year", log_q[2][11:8], 3);

    // Enable dropped while minute is presented.
    log_q.delete();
    n = 0;
    while (!(valid && direccion == 4'd4) && n < 300) begin @(negedge clk); n++; end
    chk("scan4_min_seen", {valid, direccion}, 5'h14);
    en = 1'b0;
    n = 0;
    while (busy && n < 100) begin @(negedge clk); n++; end
    chk("scan4_idle", busy, 0);
    reqs  = 0;
    hit21 = 0;
    repeat (30) begin
      @(negedge clk);
      if (rd_req) reqs++;
      if (rd_addr == 8'h21) hit21++;
    end
    chk("scan4_no_req", reqs, 0);
    chk("scan4_no_second", hit21, 0);
    chk("scan4_count", log_q.size(), 5);

    // Reset pulsed in the middle of a request.
    en = 1'b1;
    n = 0;
    while (!rd_req && n < 50) begin @(negedge clk); n++; end
    chk("scan5_req_seen", rd_req, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("scan5_async_drop", {rd_req, direccion, busy}, {1'b0, 4'hF, 1'b0});
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!rd_req && n < 50);
    chk("scan5_first_req", n, RC + 1);
    wait_scan("scan5");
    chk("scan5_count", log_q.size(), 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog.
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog expired");
  end

endmodule
